// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared types and defaults for the sequential 1-D convolution MAC.
//   conv_state_t : controller states (IDLE, RUN, DONE)
//   CONV_N/DW/OW : default samples per vector, bits per sample, bits per slot
//   conv_accw()  : accumulator width wide enough that a full slot sum of
//                  N products of two DW-bit values can never overflow
// ---------------------------------------------------------------------------
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } conv_state_t;

   localparam int CONV_N  = 8;
   localparam int CONV_DW = 4;
   localparam int CONV_OW = 4;

   function automatic int conv_accw(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/conv_seq_mac_if.sv
// ---------------------------------------------------------------------------
// conv_seq_mac_if
// Start/busy/done handshake plus operand and result buses of conv_seq_mac.
//   start : request, honoured only while the block is idle
//   x_in  : N packed samples,      x[i] = x_in[i*DW +: DW]
//   h_in  : N packed coefficients, h[j] = h_in[j*DW +: DW]
//   busy  : high while an operation is in flight (RUN and DONE)
//   done  : one-cycle pulse on the edge y_out updates
//   y_out : 2N packed result slots, slot k = y_out[k*OW +: OW]
// Modports: master (requester side), slave (conv_seq_mac side).
// ---------------------------------------------------------------------------
interface conv_seq_mac_if
   import conv_pkg::*;
#(
   parameter int N  = CONV_N,
   parameter int DW = CONV_DW,
   parameter int OW = CONV_OW
) ();

   logic              start;
   logic [N*DW-1:0]   x_in;
   logic [N*DW-1:0]   h_in;
   logic              busy;
   logic              done;
   logic [2*N*OW-1:0] y_out;

   modport master (
      output start, x_in, h_in,
      input  busy, done, y_out
   );

   modport slave (
      input  start, x_in, h_in,
      output busy, done, y_out
   );

endinterface

// File: rtl/conv_mac.sv
// ---------------------------------------------------------------------------
// conv_mac
// Single multiply-accumulate stage shared by every tap of the convolution.
//   clk, rst : clock, synchronous active-high reset
//   a, b     : DW-bit unsigned operands
//   valid    : add a*b this edge (otherwise add zero)
//   clear    : zero the accumulator this edge (wins over valid)
//   acc      : registered accumulator
//   term     : the gated product being added this edge, so the caller can
//              see the post-edge sum (acc + term) on the same cycle
// ---------------------------------------------------------------------------
module conv_mac
   import conv_pkg::*;
#(
   parameter int DW   = CONV_DW,
   parameter int ACCW = conv_accw(CONV_N, CONV_DW)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic            valid,
   input  logic            clear,
   output logic [ACCW-1:0] acc,
   output logic [ACCW-1:0] term
);

   logic [2*DW-1:0] prod;
   logic [ACCW-1:0] acc_reg;

   assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
   assign term = valid ? ACCW'(prod) : '0;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc_reg <= '0;
      end else begin
         acc_reg <= acc_reg + term;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/conv_seq_mac.sv
// ---------------------------------------------------------------------------
// conv_seq_mac
// Sequential 1-D linear convolution y[k] = sum_j x[k-j]*h[j] of two N-sample
// unsigned vectors using one time-multiplexed MAC. Each slot k takes N edges
// (j = 0..N-1), so an operation runs 2N*N edges, then one DONE cycle.
//   clk, rst : clock, synchronous active-high reset (aborts a running op)
//   bus      : conv_seq_mac_if.slave (start, x_in, h_in, busy, done, y_out)
// Build option: define CONV_SATURATE_EN to clamp each slot to 2^OW-1;
// the default build keeps the low OW bits of the slot sum.
// ---------------------------------------------------------------------------
module conv_seq_mac
   import conv_pkg::*;
#(
   parameter  int N    = CONV_N,
   parameter  int DW   = CONV_DW,
   parameter  int OW   = CONV_OW,
   localparam int ACCW = conv_accw(N, DW)
) (
   input logic           clk,
   input logic           rst,
   conv_seq_mac_if.slave bus
);

   localparam int KW = $clog2(2 * N);
   localparam int JW = $clog2(N);

   conv_state_t       state_reg;
   logic [KW-1:0]     k_reg;
   logic [JW-1:0]     j_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [2*N*OW-1:0] y_out_reg;
   logic [2*N*OW-1:0] y_next;

   logic [DW-1:0]     x_reg   [N];
   logic [DW-1:0]     h_reg   [N];
   logic [OW-1:0]     res_reg [2*N];

   logic [KW-1:0]     diff;
   logic [JW-1:0]     idx;
   logic              tap_valid;
   logic              last_tap;
   logic              last_slot;
   logic              mac_clear;
   logic [ACCW-1:0]   mac_acc;
   logic [ACCW-1:0]   mac_term;
   logic [ACCW-1:0]   slot_sum;
   logic [OW-1:0]     slot_val;

   // Tap j of slot k reads x[k-j]; taps falling outside 0..N-1 add zero.
   assign diff      = k_reg - KW'(j_reg);
   assign idx       = diff[JW-1:0];
   assign tap_valid = (state_reg == RUN) && (k_reg >= KW'(j_reg)) && (diff < KW'(N));
   assign last_tap  = (j_reg == JW'(N - 1));
   assign last_slot = (k_reg == KW'(2 * N - 1));

   // Outside RUN the accumulator is held at zero, so a new op starts clean.
   // On the last tap it is cleared for the next slot while the complete
   // sum (acc + this edge's term) goes to the result buffer.
   assign mac_clear = (state_reg != RUN) || last_tap;

   conv_mac #(
      .DW   (DW),
      .ACCW (ACCW)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .a     (x_reg[idx]),
      .b     (h_reg[j_reg]),
      .valid (tap_valid),
      .clear (mac_clear),
      .acc   (mac_acc),
      .term  (mac_term)
   );

   assign slot_sum = mac_acc + mac_term;

`ifdef CONV_SATURATE_EN
   assign slot_val = ((slot_sum >> OW) != '0) ? {OW{1'b1}} : slot_sum[OW-1:0];
`else
   // Upper bits are intentionally dropped (modulo 2^OW).
   logic unused_hi;
   assign unused_hi = ^(slot_sum >> OW);
   assign slot_val  = slot_sum[OW-1:0];
`endif

   // Operand capture on the accepting edge; inputs are don't-care afterwards.
   always_ff @(posedge clk) begin
      if (state_reg == IDLE && bus.start) begin
         for (int i = 0; i < N; i++) begin
            x_reg[i] <= bus.x_in[i*DW +: DW];
            h_reg[i] <= bus.h_in[i*DW +: DW];
         end
      end
   end

   // Result buffer: slot k written on its last tap.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2 * N; i++) begin
            res_reg[i] <= '0;
         end
      end else if (state_reg == RUN && last_tap) begin
         res_reg[k_reg] <= slot_val;
      end
   end

   // The final slot is completed on the same edge y_out loads, so it is
   // taken straight from the MAC rather than from the buffer.
   for (genvar gi = 0; gi < 2 * N; gi++) begin : g_pack
      if (gi == 2 * N - 1) begin : g_last
         assign y_next[gi*OW +: OW] = slot_val;
      end else begin : g_buf
         assign y_next[gi*OW +: OW] = res_reg[gi];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         k_reg     <= '0;
         j_reg     <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         y_out_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  state_reg <= RUN;
                  busy_reg  <= 1'b1;
                  k_reg     <= '0;
                  j_reg     <= '0;
               end
            end
            RUN: begin
               if (last_tap) begin
                  j_reg <= '0;
                  k_reg <= k_reg + KW'(1);
                  if (last_slot) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                     y_out_reg <= y_next;
                  end
               end else begin
                  j_reg <= j_reg + JW'(1);
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_reg;
   assign bus.done  = done_reg;
   assign bus.y_out = y_out_reg;

endmodule

// File: tb/tb_conv_seq_mac.sv
// ---------------------------------------------------------------------------
// tb_conv_seq_mac
// Directed bench for conv_seq_mac at default parameters. A behavioural model
// computes each convolution with plain loops at the accepting edge and
// tracks the expected busy/done/y_out timeline by counting edges; outputs
// are compared against it on every falling edge. Literal expectations for
// the documented vectors pin the model. Honours CONV_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_conv_seq_mac;

   localparam int N  = 8;
   localparam int DW = 4;
   localparam int OW = 4;
   localparam int XW = N * DW;
   localparam int YW = 2 * N * OW;
   localparam int RUN_EDGES = 2 * N * N;

   logic clk = 1'b0;
   logic rst;

   conv_seq_mac_if #(.N(N), .DW(DW), .OW(OW)) bus ();

   conv_seq_mac #(.N(N), .DW(DW), .OW(OW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit check_en = 1'b0;

   // ---------------- behavioural model ----------------
   function automatic logic [YW-1:0] conv_ref(input logic [XW-1:0] xv, input logic [XW-1:0] hv);
      logic [YW-1:0] y;
      int unsigned   s;
      y = '0;
      for (int k = 0; k < 2 * N; k++) begin
         s = 0;
         for (int j = 0; j < N; j++) begin
            if (k - j >= 0 && k - j < N) begin
               s += xv[(k-j)*DW +: DW] * hv[j*DW +: DW];
            end
         end
`ifdef CONV_SATURATE_EN
         if (s > (1 << OW) - 1) s = (1 << OW) - 1;
`endif
         y[k*OW +: OW] = s[OW-1:0];
      end
      return y;
   endfunction

   bit            m_active  = 1'b0;
   int            m_cnt     = 0;
   logic          exp_busy  = 1'b0;
   logic          exp_done  = 1'b0;
   logic [YW-1:0] exp_y     = '0;
   logic [YW-1:0] m_pending = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_active <= 1'b0;
         m_cnt    <= 0;
         exp_busy <= 1'b0;
         exp_done <= 1'b0;
         exp_y    <= '0;
      end else if (m_active) begin
         m_cnt    <= m_cnt + 1;
         exp_done <= (m_cnt + 1 == RUN_EDGES);
         if (m_cnt + 1 == RUN_EDGES) exp_y <= m_pending;
         if (m_cnt + 1 == RUN_EDGES + 1) begin
            m_active <= 1'b0;
            exp_busy <= 1'b0;
         end
      end else begin
         exp_done <= 1'b0;
         if (bus.start) begin
            m_active  <= 1'b1;
            m_cnt     <= 0;
            exp_busy  <= 1'b1;
            m_pending <= conv_ref(bus.x_in, bus.h_in);
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // One cycle: wait for the falling edge, then compare against the model.
   task automatic tick();
      @(negedge clk);
      if (check_en) begin
         chk("busy",  bus.busy,  exp_busy);
         chk("done",  bus.done,  exp_done);
         chk("y_out", bus.y_out, exp_y);
      end
   endtask

   task automatic run_op(input logic [XW-1:0] xv, input logic [XW-1:0] hv, input string tag, output int lat);
      bus.x_in  = xv;
      bus.h_in  = hv;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 0;
      while (lat < 300) begin
         tick();
         lat++;
         if (bus.done === 1'b1) break;
      end
      if (lat >= 300) chk({tag, "_timeout"}, 128'(lat), 128'(RUN_EDGES));
      $display("op %s: x=%h h=%h y=%h latency=%0d", tag, xv, hv, bus.y_out, lat);
   endtask

   localparam logic [YW-1:0] Y_RAMP = 64'h0123456787654321;
`ifdef CONV_SATURATE_EN
   localparam logic [YW-1:0] Y_ONES = 64'h0FFFFFFFFFFFFFFF;
`else
   localparam logic [YW-1:0] Y_ONES = 64'h0123456787654321;
`endif

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int n;
      int dones;
      int done_at;
      int last_done;
      int low_run;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.x_in  = '0;
      bus.h_in  = '0;
      repeat (2) @(negedge clk);
      check_en = 1'b1;
      chk("reset_busy",  bus.busy,  1'b0);
      chk("reset_done",  bus.done,  1'b0);
      chk("reset_y_out", bus.y_out, '0);
      rst = 1'b0;
      tick();

      // Ones: ramp up then down.
      run_op(32'h11111111, 32'h11111111, "ones", lat);
      chk("ones_latency", 128'(lat), 128'd128);
      chk("ones_y", bus.y_out, Y_RAMP);
      repeat (2) tick();

      // Impulse response reproduces x.
      run_op(32'h87654321, 32'h00000001, "impulse", lat);
      chk("impulse_latency", 128'(lat), 128'd128);
      chk("impulse_y", bus.y_out, 64'h0000000087654321);
      repeat (2) tick();

      // All-ones: slot sums exceed 4 bits.
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, "allones", lat);
      chk("allones_latency", 128'(lat), 128'd128);
`ifndef CONV_SATURATE_EN
      chk("allones_slot0", bus.y_out[3:0],   4'h1);
      chk("allones_slot7", bus.y_out[31:28], 4'h8);
`endif
      chk("allones_y", bus.y_out, Y_ONES);
      repeat (2) tick();

      // start re-pulsed mid-run with other operands must be ignored.
      bus.x_in  = 32'h11111111;
      bus.h_in  = 32'h11111111;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      dones = 0;
      done_at = -1;
      while (n < 140) begin
         if (n == 49) begin
            bus.start = 1'b1;
            bus.x_in  = 32'h22222222;
            bus.h_in  = 32'h22222222;
         end else if (n == 50) begin
            bus.start = 1'b0;
         end
         tick();
         n++;
         if (bus.done === 1'b1) begin
            dones++;
            done_at = n;
         end
      end
      $display("op repulse: y=%h dones=%0d done_at=%0d", bus.y_out, dones, done_at);
      chk("repulse_dones", 128'(dones), 128'd1);
      chk("repulse_done_at", 128'(done_at), 128'd128);
      chk("repulse_y", bus.y_out, Y_RAMP);

      // Reset on the 60th run edge aborts and clears the result.
      bus.x_in  = 32'h33333333;
      bus.h_in  = 32'h11111111;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 1; i < 60; i++) tick();
      rst = 1'b1;
      tick();
      $display("op abort: busy=%0b done=%0b y=%h", bus.busy, bus.done, bus.y_out);
      chk("abort_busy",  bus.busy,  1'b0);
      chk("abort_done",  bus.done,  1'b0);
      chk("abort_y_out", bus.y_out, '0);
      rst = 1'b0;
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, "after_abort", lat);
      chk("after_abort_latency", 128'(lat), 128'd128);
      chk("after_abort_y", bus.y_out, Y_ONES);
      repeat (2) tick();

      // start held high: back-to-back operations.
      bus.start = 1'b1;
      last_done = -1;
      low_run = 0;
      dones = 0;
      for (int c = 0; c < 400; c++) begin
         tick();
         if (bus.done === 1'b1) begin
            dones++;
            if (last_done >= 0) chk("held_done_spacing", 128'(c - last_done), 128'd130);
            last_done = c;
         end
         if (bus.busy === 1'b1) begin
            if (low_run > 0) chk("held_busy_gap", 128'(low_run), 128'd1);
            low_run = 0;
         end else begin
            low_run++;
         end
      end
      $display("op held: dones=%0d last_done=%0d", dones, last_done);
      chk("held_dones", 128'(dones), 128'd3);
      bus.start = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) chk("drain_timeout", bus.busy, 1'b0);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
